// File: rtl/spi_ctrl_pkg.sv
// Shared types and command-byte field definitions for the SPI command sequencer.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWdata,
    StRdIssue,
    StRdCap,
    StRdata
  } state_e;

  localparam int unsigned CMD_WR_BIT   = 7;
  localparam int unsigned CMD_RSV_BIT  = 6;
  localparam int unsigned CMD_ADDR_LSB = 0;

  localparam logic [7:0] DATA_OUT_IDLE = 8'h00;

  function automatic logic cmd_is_write(input logic [7:0] cmd);
    return cmd[CMD_WR_BIT];
  endfunction

  function automatic logic cmd_is_bad(input logic [7:0] cmd);
    return cmd[CMD_RSV_BIT];
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop single-bit synchronizer with a selectable reset value.
module sync_2ff #(
  parameter bit ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_cmd_ctrl.sv
// Decodes SPI bridge bytes into two-byte register transactions with registered strobes.
// Optional inter-byte timeout is built when SPI_CMD_TIMEOUT_EN is defined.
module spi_cmd_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W         = 6,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              byte_sync,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_wr,
  output logic [7:0]        reg_wdata,
  output logic              reg_rd,
  input  logic [7:0]        reg_rdata,
  output logic              cmd_err
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("spi_cmd_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  logic cs_n_s;

  sync_2ff #(
    .ResetVal(1'b1)
  ) u_cs_sync (
    .clk_i(clk),
    .rst_i(rst),
    .d_i  (cs_n),
    .q_o  (cs_n_s)
  );

  state_e            state_q, state_d;
  logic [7:0]        data_out_q, data_out_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [7:0]        reg_wdata_q, reg_wdata_d;
  logic              reg_wr_q, reg_wr_d;
  logic              reg_rd_q, reg_rd_d;
  logic              cmd_err_q, cmd_err_d;

`ifdef SPI_CMD_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout;
`endif

  always_comb begin
    state_d     = state_q;
    data_out_d  = data_out_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_wr_d    = 1'b0;
    reg_rd_d    = 1'b0;
    cmd_err_d   = 1'b0;
`ifdef SPI_CMD_TIMEOUT_EN
    cnt_d   = cnt_q;
    timeout = (cnt_q == CntLast);
    if ((state_q == StWdata || state_q == StRdata) && cnt_q != CntMax) begin
      cnt_d = cnt_q + CntW'(1);
    end
`endif

    // Deselect wins over any byte arriving in the same cycle.
    if (cs_n_s) begin
      state_d    = StIdle;
      data_out_d = DATA_OUT_IDLE;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (byte_sync) begin
            reg_addr_d = data_in[CMD_ADDR_LSB +: ADDR_W];
            if (cmd_is_bad(data_in)) begin
              cmd_err_d = 1'b1;
            end else if (cmd_is_write(data_in)) begin
              state_d = StWdata;
            end else begin
              state_d  = StRdIssue;
              reg_rd_d = 1'b1;
            end
          end
        end
        StWdata: begin
          if (byte_sync) begin
            reg_wr_d    = 1'b1;
            reg_wdata_d = data_in;
            state_d     = StIdle;
          end
`ifdef SPI_CMD_TIMEOUT_EN
          else if (timeout) begin
            cmd_err_d = 1'b1;
            state_d   = StIdle;
          end
`endif
        end
        StRdIssue: begin
          if (byte_sync) begin
            cmd_err_d = 1'b1;
            state_d   = StIdle;
          end else begin
            state_d = StRdCap;
          end
        end
        StRdCap: begin
          if (byte_sync) begin
            cmd_err_d = 1'b1;
            state_d   = StIdle;
          end else begin
            data_out_d = reg_rdata;
            state_d    = StRdata;
          end
        end
        StRdata: begin
          if (byte_sync) begin
            data_out_d = DATA_OUT_IDLE;
            state_d    = StIdle;
          end
`ifdef SPI_CMD_TIMEOUT_EN
          else if (timeout) begin
            cmd_err_d  = 1'b1;
            data_out_d = DATA_OUT_IDLE;
            state_d    = StIdle;
          end
`endif
        end
        default: begin
          state_d    = StIdle;
          data_out_d = DATA_OUT_IDLE;
        end
      endcase
    end

`ifdef SPI_CMD_TIMEOUT_EN
    if (state_d != state_q && (state_d == StWdata || state_d == StRdata)) begin
      cnt_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      data_out_q  <= DATA_OUT_IDLE;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_out_q  <= data_out_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wr_q    <= reg_wr_d;
      reg_rd_q    <= reg_rd_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

`ifdef SPI_CMD_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign data_out  = data_out_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_wr    = reg_wr_q;
  assign reg_rd    = reg_rd_q;
  assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Scoreboard bench for spi_cmd_ctrl: stimulus queues expected events, a monitor pops them.
module tb_spi_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs_n = 1'b1;
  logic       byte_sync = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic [5:0] reg_addr;
  logic       reg_wr;
  logic [7:0] reg_wdata;
  logic       reg_rd;
  logic [7:0] reg_rdata = 8'h00;
  logic       cmd_err;

  spi_cmd_ctrl #(
    .ADDR_W        (6),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cs_n     (cs_n),
    .byte_sync(byte_sync),
    .data_in  (data_in),
    .data_out (data_out),
    .reg_addr (reg_addr),
    .reg_wr   (reg_wr),
    .reg_wdata(reg_wdata),
    .reg_rd   (reg_rd),
    .reg_rdata(reg_rdata),
    .cmd_err  (cmd_err)
  );

  always #5 clk = ~clk;

  typedef enum int {EvWr, EvRd, EvErr, EvDout} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [5:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         err_seen = 0;
  logic [7:0] model_mem[64];
  logic [7:0] rf[64];
  logic [7:0] dout_prev = 8'h00;

  // Register file the DUT talks to; read data appears the cycle after reg_rd.
  always @(posedge clk) begin
    if (!rst) begin
      if (reg_wr) rf[reg_addr] <= reg_wdata;
      if (reg_rd) reg_rdata <= rf[reg_addr];
    end
  end

  task automatic push(input ev_kind_e k, input logic [5:0] a, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input ev_kind_e k, input logic [5:0] a, input logic [7:0] d);
    ev_t e;
    logic bad;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d addr=%h data=%h required no event", k, a, d);
    end else begin
      e = exp_q.pop_front();
      bad = (e.kind != k);
      if ((k == EvWr || k == EvRd) && e.addr != a) bad = 1'b1;
      if ((k == EvWr || k == EvDout) && e.data != d) bad = 1'b1;
      if (bad) begin
        errors++;
        $display("FAIL event got kind=%0d addr=%h data=%h required kind=%0d addr=%h data=%h",
                 k, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (reg_wr) check_ev(EvWr, reg_addr, reg_wdata);
      if (reg_rd) check_ev(EvRd, reg_addr, 8'h00);
      if (cmd_err) begin
        err_seen++;
        check_ev(EvErr, 6'h00, 8'h00);
      end
      if (dout_prev == 8'h00 && data_out != 8'h00) check_ev(EvDout, 6'h00, data_out);
    end
    dout_prev = data_out;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", name, act, req);
    end
  endtask

  // All drivers assume they start #1 after a rising edge and return the same way.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] b);
    byte_sync = 1'b1;
    data_in   = b;
    @(posedge clk);
    #1;
    byte_sync = 1'b0;
    data_in   = $urandom_range(0, 255);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    logic [5:0] a;
    logic [7:0] d;
    int         kind;
    int         e0;

    for (int i = 0; i < 64; i++) begin
      v = 8'($urandom_range(1, 255));
      model_mem[i] = v;
      rf[i] <= v;
    end
    model_mem[2] = 8'hA7;
    rf[2] <= 8'hA7;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_data_out", 32'(data_out), 32'h00);
    chk("rst_reg_addr", 32'(reg_addr), 32'h00);
    chk("rst_reg_wdata", 32'(reg_wdata), 32'h00);
    chk("rst_reg_wr", 32'(reg_wr), 32'h0);
    chk("rst_reg_rd", 32'(reg_rd), 32'h0);
    chk("rst_cmd_err", 32'(cmd_err), 32'h0);
    cs_n = 1'b0;
    idle(3);

    // Directed write
    push(EvWr, 6'h05, 8'h3C);
    model_mem[5] = 8'h3C;
    pulse(8'h85);
    pulse(8'h3C);
    chk("wr_strobe", 32'(reg_wr), 32'h1);
    chk("wr_addr", 32'(reg_addr), 32'h05);
    chk("wr_data", 32'(reg_wdata), 32'h3C);
    chk("wr_no_rd", 32'(reg_rd), 32'h0);
    idle(1);
    chk("wr_one_cycle", 32'(reg_wr), 32'h0);

    // Directed read with exact latency
    push(EvRd, 6'h02, 8'h00);
    push(EvDout, 6'h00, 8'hA7);
    pulse(8'h02);
    chk("rd_strobe_n1", 32'(reg_rd), 32'h1);
    idle(1);
    chk("rd_single_n2", 32'(reg_rd), 32'h0);
    chk("rd_dout_n2", 32'(data_out), 32'h00);
    idle(1);
    chk("rd_dout_n3", 32'(data_out), 32'hA7);
    pulse(8'hFF);
    chk("rd_dout_after_dummy", 32'(data_out), 32'h00);

    // Reserved bit set, then prove FSM stayed in idle
    push(EvErr, 6'h00, 8'h00);
    pulse(8'h40);
    chk("rsv_err", 32'(cmd_err), 32'h1);
    push(EvWr, 6'h01, 8'h22);
    model_mem[1] = 8'h22;
    pulse(8'h81);
    pulse(8'h22);
    idle(1);

    // Read too early: second byte while in capture
    push(EvRd, 6'h02, 8'h00);
    push(EvErr, 6'h00, 8'h00);
    pulse(8'h02);
    idle(1);
    pulse(8'h99);
    chk("early_err", 32'(cmd_err), 32'h1);
    chk("early_dout", 32'(data_out), 32'h00);
    idle(2);
    chk("early_dout_later", 32'(data_out), 32'h00);

    // Truncated frame followed by a good one
    pulse(8'h81);
    cs_n = 1'b1;
    idle(4);
    cs_n = 1'b0;
    idle(3);
    push(EvWr, 6'h04, 8'h11);
    model_mem[4] = 8'h11;
    pulse(8'h84);
    pulse(8'h11);
    idle(2);

    // Randomized mix
    for (int t = 0; t < 80; t++) begin
      kind = $urandom_range(0, 9);
      a    = 6'($urandom_range(0, 63));
      if (kind < 4) begin
        d = 8'($urandom_range(1, 255));
        push(EvWr, a, d);
        model_mem[a] = d;
        pulse({2'b10, a});
        idle($urandom_range(0, 3));
        pulse(d);
      end else if (kind < 7) begin
        push(EvRd, a, 8'h00);
        push(EvDout, 6'h00, model_mem[a]);
        pulse({2'b00, a});
        idle($urandom_range(2, 5));
        pulse(8'($urandom_range(0, 255)));
      end else if (kind < 8) begin
        push(EvErr, 6'h00, 8'h00);
        pulse({1'($urandom_range(0, 1)), 1'b1, a});
      end else begin
        push(EvRd, a, 8'h00);
        push(EvErr, 6'h00, 8'h00);
        pulse({2'b00, a});
        idle($urandom_range(0, 1));
        pulse(8'($urandom_range(0, 255)));
      end
      idle($urandom_range(0, 2));
    end
    idle(4);

    // Inter-byte timeout behaviour
`ifdef SPI_CMD_TIMEOUT_EN
    push(EvErr, 6'h00, 8'h00);
    pulse(8'h83);
    idle(15);
    chk("timeout_not_early", 32'(cmd_err), 32'h0);
    idle(1);
    chk("timeout_pulse", 32'(cmd_err), 32'h1);
    idle(2);
`else
    e0 = err_seen;
    pulse(8'h83);
    idle(1000);
    chk("no_timeout_pulse", 32'(err_seen - e0), 32'h0);
    cs_n = 1'b1;
    idle(4);
    cs_n = 1'b0;
    idle(3);
`endif

    // Reset while in RDATA
    push(EvRd, 6'h02, 8'h00);
    push(EvDout, 6'h00, model_mem[2]);
    pulse(8'h02);
    idle(2);
    chk("pre_rst_dout", 32'(data_out), 32'(model_mem[2]));
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_data_out", 32'(data_out), 32'h00);
    chk("mid_rst_reg_addr", 32'(reg_addr), 32'h00);
    chk("mid_rst_reg_rd", 32'(reg_rd), 32'h0);
    chk("mid_rst_reg_wr", 32'(reg_wr), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);
    push(EvWr, 6'h07, 8'h5A);
    model_mem[7] = 8'h5A;
    pulse(8'h87);
    pulse(8'h5A);
    idle(4);

    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
